psum_drain: RTL and testbench
=============================

// Module: psum_drain
// PURPOSE
//  Read-side engine for the partial-sum BRAMs written by the array controller. On start, sweeps all
//  ROWS psum memories through their AXI-side read port (row 0 first, ascending word index) and
//  streams each 64-bit psum as one AXI4-Stream beat toward the DMA/host. Sits beside the memory
//  wrapper and drives its axi_psum_mem_addr inputs.
// PARAMETERS
//  ROWS        3   number of psum memories / PE rows
//  RD_LAT      2   BRAM address-to-data latency in cycles (primitive output register enabled)
//  FIFO_DEPTH  4   output buffer entries; must be >= RD_LAT+1
// PORTS
//  clk             in   1            single clock; BRAMs and stream share it
//  rst             in   1            asynchronous, active-high reset
//  start           in   1            one-cycle pulse; sampled only in IDLE
//  base_addr       in   32           byte address of word 0 in every psum memory (8-byte aligned)
//  words_per_row   in   16           psums to read per row
//  busy            out  1            high from accepted start until done
//  done            out  1            one-cycle pulse after final beat handshake
//  psum_rd_addr    out  [ROWS][32]   byte read address, same value driven to every row's port b
//  psum_rd_data    in   [ROWS][64]   port-b read data, valid RD_LAT cycles after address
//  m_axis_tdata    out  64           psum beat
//  m_axis_tvalid   out  1
//  m_axis_tready   in   1
//  m_axis_tlast    out  1            high on the last beat of the last row only
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, tvalid=0, tlast=0, tdata=0, psum_rd_addr=0; FIFO and
//    in-flight pipeline cleared. Reset mid-sweep abandons it; no further beats are emitted.
//  - FSM IDLE -> ISSUE on start (latch base_addr, words_per_row; row=0, word=0).
//    ISSUE -> FLUSH after the read for (row=ROWS-1, word=words_per_row-1) is issued.
//    FLUSH -> DONE when pipeline and FIFO are empty, i.e. the tlast beat has been accepted.
//    DONE -> IDLE next cycle; done=1 during DONE only. busy=1 in ISSUE, FLUSH and DONE.
//  - start with words_per_row==0: IDLE -> DONE directly; no reads, no beats, done one cycle later.
//  - start while not IDLE is ignored; inputs latched only at acceptance.
//  - Address: psum_rd_addr = base_addr + (word << 3), 32-bit wrap-around. word increments per issue;
//    at words_per_row-1 it resets to 0 and row increments.
//  - Issue rule (credit): a read issues in ISSUE iff fifo_count + inflight < FIFO_DEPTH, counting any
//    beat popped in the same cycle. The FIFO therefore never overflows and tready may drop at any
//    time with no data loss. Zero issue bubbles while tready stays high.
//  - Each issued read carries {row, last} through an RD_LAT-stage valid shift register. On exit,
//    psum_rd_data[row] and last are pushed into the FIFO.
//  - Stream: tvalid = FIFO non-empty. tdata/tlast come from the FIFO head and stay stable while
//    tvalid && !tready. Pop on tvalid && tready. Push and pop in the same cycle, full or empty, are
//    both legal.
//  - Latency: the first beat's tvalid rises RD_LAT+1 cycles after the accepted start pulse.
//  - Beat order: row-major, (r0,w0..wN-1), (r1,w0..), ... Total beats = ROWS*words_per_row.
// STRUCTURE
//  - ws_pkg gains: typedef logic [63:0] psum_t; typedef enum {DR_IDLE, DR_ISSUE, DR_FLUSH, DR_DONE}
//    drain_state_t; localparam PSUM_BYTES = 8.
//  - Sub-module psum_drain_fifo: sync FIFO of {tlast, psum_t} with FIFO_DEPTH entries and count output.
//    The top level holds the FSM, counters, credit logic and the tag pipeline.
// TESTING
//  1 ROWS=3, base=0x100, wpr=4, tready=1: 12 beats r0w0..r2w3, addrs 0x100..0x118 per row,
//    tlast on beat 12 only, done 1 cycle after that beat; first tvalid at start+3.
//  2 Same sweep, tready toggling 1,0,0,1,... random: beat sequence identical to case 1, no
//    duplicates or drops, and fifo_count never exceeds 4 (assertion).
//  3 wpr=0: done pulses 1 cycle after start, tvalid stays 0, psum_rd_addr never changes.
//  4 Second start pulsed mid-sweep (wpr=4): ignored, exactly 12 beats. A new start after done gives
//    a second full sweep.
//  5 rst asserted after beat 5 with tvalid high: tvalid=0 and busy=0 immediately. A fresh start
//    with wpr=2 gives exactly 6 beats with correct data.
//  6 base=0xFFFF_FFF8, wpr=2: addresses 0xFFFF_FFF8 then 0x0000_0000 per row.

Source files
------------

// File: rtl/ws_pkg.sv
// rtl/ws_pkg.sv - shared psum types, drain FSM states and address helper
package ws_pkg;

    typedef logic [63:0] psum_t;

    typedef enum logic [1:0] {
        DR_IDLE  = 2'd0,
        DR_ISSUE = 2'd1,
        DR_FLUSH = 2'd2,
        DR_DONE  = 2'd3
    } drain_state_t;

    localparam int PSUM_BYTES      = 8;
    localparam int PSUM_ADDR_SHIFT = $clog2(PSUM_BYTES);

    // Byte address of a psum word; wraps at 32 bits.
    function automatic logic [31:0] psum_word_addr(input logic [31:0] base, input logic [15:0] word);
        return base + ({16'd0, word} << PSUM_ADDR_SHIFT);
    endfunction

endpackage

// File: rtl/psum_drain_fifo.sv
// rtl/psum_drain_fifo.sv - output buffer of {tlast, psum} beats with occupancy count
module psum_drain_fifo
    import ws_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  psum_t            push_data,
    input  logic             push_last,
    input  logic             pop,
    output psum_t            head_data,
    output logic             head_last,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    psum_t            mem_data [DEPTH];
    logic             mem_last [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign wr_en     = push && (!full || pop);
    assign rd_en     = pop && !empty;
    assign head_data = mem_data[rd_ptr];
    assign head_last = mem_last[rd_ptr];

    // Storage, pointers and occupancy; contents cleared so tdata reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
        end else begin
            if (wr_en) begin
                mem_data[wr_ptr] <= push_data;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (wr_en && !rd_en) begin
                count <= count + 1'b1;
            end else if (!wr_en && rd_en) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - sweeps all psum BRAMs through port b and streams each word as one beat
module psum_drain
    import ws_pkg::*;
#(
    parameter int ROWS       = 3,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [15:0]            words_per_row,
    output logic                   busy,
    output logic                   done,
    output logic [ROWS-1:0][31:0]  psum_rd_addr,
    input  logic [ROWS-1:0][63:0]  psum_rd_data,
    output logic [63:0]            m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(RD_LAT + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

    drain_state_t      state;
    logic [ROW_W-1:0]  row_q;
    logic [15:0]       word_q;
    logic [31:0]       base_q;
    logic [15:0]       wpr_q;
    logic [31:0]       addr_q;

    logic [RD_LAT-1:0] tag_valid;
    logic [RD_LAT-1:0] tag_last;
    logic [ROW_W-1:0]  tag_row [RD_LAT];

    logic [INF_W-1:0]  inflight;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              pop;
    logic              issue;
    logic              word_last;
    logic              row_last;
    logic              issue_last;
    logic [15:0]       next_word;

    assign pop        = m_axis_tvalid && m_axis_tready;
    assign word_last  = (word_q == wpr_q - 16'd1);
    assign row_last   = (row_q == ROW_W'(ROWS - 1));
    assign issue_last = word_last && row_last;
    assign next_word  = word_last ? 16'd0 : word_q + 16'd1;

    // Count reads still travelling through the BRAM latency.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + INF_W'(tag_valid[i]);
        end
    end

    // Credit: every issued read already owns a FIFO slot, so a beat leaving this cycle frees one.
    assign occ   = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(pop);
    assign issue = (state == DR_ISSUE) && (occ < OCC_W'(FIFO_DEPTH));

    // Sweep FSM with row/word counters and the registered read address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= DR_IDLE;
            row_q  <= '0;
            word_q <= '0;
            base_q <= '0;
            wpr_q  <= '0;
            addr_q <= '0;
        end else begin
            case (state)
                DR_IDLE: begin
                    if (start) begin
                        row_q  <= '0;
                        word_q <= '0;
                        base_q <= base_addr;
                        wpr_q  <= words_per_row;
                        if (words_per_row == 16'd0) begin
                            state <= DR_DONE;
                        end else begin
                            addr_q <= base_addr;
                            state  <= DR_ISSUE;
                        end
                    end
                end
                DR_ISSUE: begin
                    if (issue) begin
                        word_q <= next_word;
                        addr_q <= psum_word_addr(base_q, next_word);
                        if (word_last) begin
                            row_q <= row_q + 1'b1;
                        end
                        if (issue_last) begin
                            state <= DR_FLUSH;
                        end
                    end
                end
                DR_FLUSH: begin
                    // Leave as the tlast beat is accepted so done follows it by one cycle.
                    if (inflight == '0 &&
                        (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop))) begin
                        state <= DR_DONE;
                    end
                end
                default: begin
                    state <= DR_IDLE;
                end
            endcase
        end
    end

    // Tag pipeline carrying {row, last} alongside each read for RD_LAT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            tag_last  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_row[i] <= '0;
            end
        end else begin
            tag_valid[0] <= issue;
            tag_last[0]  <= issue_last;
            tag_row[0]   <= row_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
                tag_row[i]   <= tag_row[i-1];
            end
        end
    end

    psum_drain_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_valid[RD_LAT-1]),
        .push_data (psum_rd_data[tag_row[RD_LAT-1]]),
        .push_last (tag_last[RD_LAT-1]),
        .pop       (pop),
        .head_data (m_axis_tdata),
        .head_last (m_axis_tlast),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign busy          = (state != DR_IDLE);
    assign done          = (state == DR_DONE);

    // Every row's port b reads the same word index.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            psum_rd_addr[r] = addr_q;
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// tb/tb_psum_drain.sv - directed self-checking bench for psum_drain
module tb_psum_drain;

    localparam int ROWS   = 3;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [31:0]           base_addr = '0;
    logic [15:0]           words_per_row = '0;
    logic                  busy;
    logic                  done;
    logic [ROWS-1:0][31:0] psum_rd_addr;
    logic [ROWS-1:0][63:0] psum_rd_data;
    logic [63:0]           m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready = 1'b1;
    logic                  m_axis_tlast;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    psum_drain #(
        .ROWS       (ROWS),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .words_per_row (words_per_row),
        .busy          (busy),
        .done          (done),
        .psum_rd_addr  (psum_rd_addr),
        .psum_rd_data  (psum_rd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    // BRAM model: two register stages, content encodes row and byte address.
    logic [ROWS-1:0][31:0] a1 = '0;
    logic [ROWS-1:0][31:0] a2 = '0;
    always @(posedge clk) begin
        a1 <= psum_rd_addr;
        a2 <= a1;
    end
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            psum_rd_data[r] = {16'hC0DE, 16'(r), a2[r]};
        end
    end

    function automatic logic [63:0] exp_beat(input int r, input logic [31:0] b, input int w);
        return {16'hC0DE, 16'(r), b + 32'(w * 8)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor
    int          cyc = 0;
    logic [63:0] hs_data [$];
    bit          hs_last [$];
    int          last_hs_cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          first_tv_cyc = -1;
    int          max_cnt = 0;
    int          unstable = 0;
    int          addr_mismatch = 0;
    bit          addr_changed = 1'b0;
    logic [31:0] addr_first = '0;
    bit          prev_stall = 1'b0;
    logic [64:0] prev_beat = '0;
    int          s_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && first_tv_cyc < 0) first_tv_cyc <= cyc;
            if (prev_stall && m_axis_tvalid && {m_axis_tlast, m_axis_tdata} !== prev_beat)
                unstable <= unstable + 1;
            prev_stall <= m_axis_tvalid && !m_axis_tready;
            prev_beat  <= {m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                hs_data.push_back(m_axis_tdata);
                hs_last.push_back(m_axis_tlast);
                last_hs_cyc <= cyc;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (int'(dut.fifo_count) > max_cnt) max_cnt <= int'(dut.fifo_count);
            for (int r = 1; r < ROWS; r++)
                if (psum_rd_addr[r] !== psum_rd_addr[0]) addr_mismatch <= addr_mismatch + 1;
            if (psum_rd_addr[0] !== addr_first) addr_changed <= 1'b1;
        end
    end

    // tready driver: 0 = always ready, 1 = 1,0,0,1 then random
    int         tr_mode = 0;
    int         pidx = 0;
    logic [3:0] pat = 4'b1001;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tr_mode == 0) begin
                m_axis_tready = 1'b1;
            end else begin
                m_axis_tready = (pidx < 8) ? pat[pidx % 4] : 1'($urandom_range(0, 1));
                pidx++;
            end
        end
    end

    task automatic mon_clear();
        hs_data.delete();
        hs_last.delete();
        done_cnt      = 0;
        first_tv_cyc  = -1;
        max_cnt       = 0;
        unstable      = 0;
        addr_mismatch = 0;
        addr_changed  = 1'b0;
        addr_first    = psum_rd_addr[0];
        prev_stall    = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] w);
        @(posedge clk);
        #1;
        base_addr     = b;
        words_per_row = w;
        start         = 1'b1;
        s_edge        = cyc + 1;
        @(posedge clk);
        #1;
        start         = 1'b0;
        base_addr     = 32'hDEAD_BEE0;
        words_per_row = 16'd7;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt == 0) check({tag, "_timeout"}, 64'(0), 64'(1));
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic check_sweep(input string tag, input logic [31:0] b, input int w);
        int nb  = ROWS * w;
        int bad = 0;
        check({tag, "_beats"}, 64'(hs_data.size()), 64'(nb));
        for (int i = 0; i < hs_data.size() && i < nb; i++) begin
            if (hs_data[i] !== exp_beat(i / w, b, i % w)) bad++;
            if (hs_last[i] !== (i == nb - 1)) bad++;
        end
        check({tag, "_data"}, 64'(bad), 64'(0));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
        if (nb > 0) check({tag, "_done_lat"}, 64'(done_cyc - last_hs_cyc), 64'(1));
        check({tag, "_addr_rows"}, 64'(addr_mismatch), 64'(0));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ctl", 64'({m_axis_tvalid, m_axis_tlast, done}), 64'(0));
        check("rst_tdata", m_axis_tdata, 64'(0));
        check("rst_addr", 64'(psum_rd_addr[0]), 64'(0));
        rst = 1'b0;

        // 1: full sweep, tready held high
        tr_mode = 0;
        mon_clear();
        pulse_start(32'h100, 16'd4);
        check("c1_busy", 64'(busy), 64'(1));
        wait_done("c1", 300);
        check_sweep("c1", 32'h100, 4);
        check("c1_first_tvalid", 64'(first_tv_cyc - s_edge), 64'(RD_LAT + 1));

        // 2: tready toggling
        tr_mode = 1;
        mon_clear();
        pulse_start(32'h100, 16'd4);
        wait_done("c2", 600);
        check_sweep("c2", 32'h100, 4);
        check("c2_stable", 64'(unstable), 64'(0));
        check("c2_fifo_max_ok", 64'(max_cnt <= DEPTH), 64'(1));
        tr_mode = 0;

        // 3: zero words per row
        mon_clear();
        pulse_start(32'h4000, 16'd0);
        wait_done("c3", 50);
        check_sweep("c3", 32'h4000, 0);
        check("c3_done_lat", 64'(done_cyc - s_edge), 64'(0));
        check("c3_no_tvalid", 64'(first_tv_cyc + 1), 64'(0));
        check("c3_addr_static", 64'(addr_changed), 64'(0));

        // 4: start mid-sweep ignored, then a fresh sweep
        mon_clear();
        pulse_start(32'h200, 16'd4);
        repeat (3) @(posedge clk);
        pulse_start(32'h800, 16'd2);
        wait_done("c4a", 300);
        check_sweep("c4a", 32'h200, 4);
        mon_clear();
        pulse_start(32'h300, 16'd4);
        wait_done("c4b", 300);
        check_sweep("c4b", 32'h300, 4);

        // 5: reset mid-sweep after beat 5
        mon_clear();
        pulse_start(32'h500, 16'd4);
        begin
            int n = 0;
            while (hs_data.size() < 5 && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        check("c5_reach5", 64'(hs_data.size() >= 5), 64'(1));
        check("c5_pre_tvalid", 64'(m_axis_tvalid), 64'(1));
        rst = 1'b1;
        #1;
        check("c5_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("c5_rst_busy", 64'(busy), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_clear();
        pulse_start(32'h600, 16'd2);
        wait_done("c5", 200);
        check_sweep("c5", 32'h600, 2);

        // 6: address wrap-around
        mon_clear();
        pulse_start(32'hFFFF_FFF8, 16'd2);
        wait_done("c6", 200);
        check_sweep("c6", 32'hFFFF_FFF8, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
